sdram_s1_responder: RTL and testbench

- Avalon-MM slave that emulates the SDRAM controller's s1 port: waitrequest, pipelined reads, byte-enabled writes.
- Backed by on-chip block RAM.
- Stands in for the real SDRAM controller under the bus master in simulation and in FPGA bring-up builds, so playback/record paths run without external SDRAM.
- Generates configurable wait states and a fixed read latency to exercise the master's handshake.

---
 rtl/sdram_s1_responder.sv | 162 ++++++++++++++++
 tb/tb_sdram_s1_responder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_s1_responder.sv
// Avalon-MM slave standing in for the SDRAM controller s1 port, backed by on-chip RAM.
// Optional macro SDRAM_S1_RANDOM_WAIT_EN draws a per-command wait target from an LFSR.
module sdram_s1_responder #(
  parameter int ADDR_W       = 23,
  parameter int DATA_W       = 32,
  parameter int MEM_DEPTH    = 1024,
  parameter int WAIT_CYCLES  = 1,
  parameter int READ_LATENCY = 3,
  parameter int MAX_PENDING  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [ADDR_W-1:0]     s_address,
  input  logic [DATA_W/8-1:0]   s_byteenable_n,
  input  logic                  s_chipselect,
  input  logic [DATA_W-1:0]     s_writedata,
  input  logic                  s_read_n,
  input  logic                  s_write_n,
  output logic [DATA_W-1:0]     s_readdata,
  output logic                  s_readdatavalid,
  output logic                  s_waitrequest,
  output logic [3:0]            o_pending,
  output logic                  o_err
);

  localparam int BE_W   = DATA_W / 8;
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int WCNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic [IDX_W-1:0]  idx;
  logic              addr_unused;
  logic              is_wr;
  logic              is_rd;
  logic              cmd;
  logic              acc;
  logic              acc_wr;
  logic              acc_rd;

  logic [WCNT_W-1:0] wcnt_q;
  logic [WCNT_W-1:0] wcnt_d;
  logic [WCNT_W-1:0] wtgt;
  logic [3:0]        pend_q;
  logic [3:0]        pend_d;
  logic              err_q;
  logic              err_d;

  logic [DATA_W-1:0]     stg_d_q [READ_LATENCY+1];
  logic [READ_LATENCY:0] stg_v_q;

  // Upper address bits alias onto the RAM; they carry no meaning here.
  assign idx         = s_address[IDX_W-1:0];
  assign addr_unused = ^s_address[ADDR_W-1:IDX_W];

  // A simultaneous read+write executes as a write, so it is never a read.
  assign is_wr = s_chipselect && !s_write_n;
  assign is_rd = s_chipselect && !s_read_n && s_write_n;
  assign cmd   = is_wr || is_rd;

`ifdef SDRAM_S1_RANDOM_WAIT_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (acc) begin
      lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign wtgt = WCNT_W'(32'(lfsr_q[2:0]) % (WAIT_CYCLES + 1));
`else
  assign wtgt = WCNT_W'(WAIT_CYCLES);
`endif

  assign s_waitrequest = !i_rst_n ||
                         (cmd && ((wcnt_q != wtgt) ||
                                  (is_rd && (pend_q == 4'(MAX_PENDING)))));

  assign acc    = cmd && !s_waitrequest;
  assign acc_wr = acc && is_wr;
  assign acc_rd = acc && is_rd;

  always_comb begin
    wcnt_d = wcnt_q;
    if (!cmd || acc) begin
      wcnt_d = '0;
    end else if (wcnt_q < wtgt) begin
      wcnt_d = wcnt_q + WCNT_W'(1);
    end
  end

  always_comb begin
    pend_d = pend_q + {3'b000, acc_rd} - {3'b000, s_readdatavalid};
  end

  always_comb begin
    err_d = err_q;
    if (s_chipselect && !s_read_n && !s_write_n) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wcnt_q <= '0;
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  // Byte-masked write port; RAM contents deliberately survive reset.
  always_ff @(posedge i_clk) begin
    if (acc_wr) begin
      for (int b = 0; b < BE_W; b++) begin
        if (!s_byteenable_n[b]) begin
          mem[idx][8*b +: 8] <= s_writedata[8*b +: 8];
        end
      end
    end
  end

  // Stage 0 captures the word at the accept edge; stage READ_LATENCY drives the bus.
  // Data only advances behind a valid bit so the last returned word is held.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stg_v_q <= '0;
      for (int k = 0; k <= READ_LATENCY; k++) begin
        stg_d_q[k] <= '0;
      end
    end else begin
      stg_v_q <= {stg_v_q[READ_LATENCY-1:0], acc_rd};
      if (acc_rd) begin
        stg_d_q[0] <= mem[idx];
      end
      for (int k = 1; k <= READ_LATENCY; k++) begin
        if (stg_v_q[k-1]) begin
          stg_d_q[k] <= stg_d_q[k-1];
        end
      end
    end
  end

  assign s_readdata      = stg_d_q[READ_LATENCY];
  assign s_readdatavalid = stg_v_q[READ_LATENCY];
  assign o_pending       = pend_q;
  assign o_err           = err_q;

endmodule

// File: tb/tb_sdram_s1_responder.sv
// Directed bench for sdram_s1_responder: default instance plus a zero-wait instance.
module tb_sdram_s1_responder;

  localparam int AW = 23;
  localparam int DW = 32;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic [AW-1:0] a_addr, b_addr;
  logic [BW-1:0] a_be_n, b_be_n;
  logic          a_cs, b_cs;
  logic [DW-1:0] a_wd, b_wd;
  logic          a_rd_n, b_rd_n, a_wr_n, b_wr_n;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          a_rvld, b_rvld, a_wait, b_wait;
  logic [3:0]    a_pend, b_pend;
  logic          a_err, b_err;

  logic [31:0] qa_d[$];
  int          qa_c[$];
  logic [31:0] qb_d[$];
  int          qb_c[$];
  int          b_first_ret = -1;
  int          b_max_pend = 0;

  sdram_s1_responder u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .s_address(a_addr), .s_byteenable_n(a_be_n),
    .s_chipselect(a_cs), .s_writedata(a_wd), .s_read_n(a_rd_n), .s_write_n(a_wr_n),
    .s_readdata(a_rdata), .s_readdatavalid(a_rvld), .s_waitrequest(a_wait),
    .o_pending(a_pend), .o_err(a_err)
  );

  sdram_s1_responder #(.WAIT_CYCLES(0)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .s_address(b_addr), .s_byteenable_n(b_be_n),
    .s_chipselect(b_cs), .s_writedata(b_wd), .s_read_n(b_rd_n), .s_write_n(b_wr_n),
    .s_readdata(b_rdata), .s_readdatavalid(b_rvld), .s_waitrequest(b_wait),
    .o_pending(b_pend), .o_err(b_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Return checker: data, in-order, latency from accept edge, pending count.
  always @(negedge clk) begin
    if (a_rvld === 1'b1) begin
      if (qa_d.size() == 0) begin
        chk("a_unexpected_rvld", 32'd1, 32'd0);
      end else begin
        chk("a_pend_at_ret", 32'(a_pend), 32'(qa_d.size()));
        chk("a_rdata", a_rdata, qa_d.pop_front());
        chk("a_latency", 32'(cyc - qa_c.pop_front()), 32'd3);
      end
    end
  end

  always @(negedge clk) begin
    if (int'(b_pend) > b_max_pend) b_max_pend = int'(b_pend);
    if (b_rvld === 1'b1) begin
      if (qb_d.size() == 0) begin
        chk("b_unexpected_rvld", 32'd1, 32'd0);
      end else begin
        if (b_first_ret < 0) b_first_ret = cyc;
        chk("b_pend_at_ret", 32'(b_pend), 32'(qb_d.size()));
        chk("b_rdata", b_rdata, qb_d.pop_front());
        chk("b_latency", 32'(cyc - qb_c.pop_front()), 32'd3);
      end
    end
  end

  task automatic drive(input bit sel, input logic cs, input logic [AW-1:0] addr,
                       input logic [BW-1:0] be_n, input logic [DW-1:0] wd,
                       input logic rd_n, input logic wr_n);
    if (sel) begin
      b_cs = cs; b_addr = addr; b_be_n = be_n; b_wd = wd; b_rd_n = rd_n; b_wr_n = wr_n;
    end else begin
      a_cs = cs; a_addr = addr; a_be_n = be_n; a_wd = wd; a_rd_n = rd_n; a_wr_n = wr_n;
    end
  endtask

  task automatic idle(input bit sel);
    drive(sel, 1'b0, '0, 4'hF, '0, 1'b1, 1'b1);
  endtask

  task automatic push(input bit sel, input logic [31:0] d, input int c);
    if (sel) begin
      qb_d.push_back(d); qb_c.push_back(c);
    end else begin
      qa_d.push_back(d); qa_c.push_back(c);
    end
  endtask

  // Counts stalled cycles; returns just after the accept edge.
  task automatic wait_acc(input bit sel, output int stalls, output int acyc, output bit ok);
    stalls = 0; acyc = 0; ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if ((sel ? b_wait : a_wait) === 1'b0) begin
        ok = 1'b1;
        break;
      end
      stalls++;
    end
    if (!ok) chk(sel ? "b_accept_timeout" : "a_accept_timeout", 32'd0, 32'd1);
    else begin
      @(posedge clk);
      #1;
      acyc = cyc;
    end
  endtask

  task automatic cmd(input bit sel, input logic [AW-1:0] addr, input logic [BW-1:0] be_n,
                     input logic [DW-1:0] wd, input logic rd_n, input logic wr_n,
                     input logic [31:0] exp, output int stalls);
    int acyc;
    bit ok;
    @(posedge clk);
    #1;
    drive(sel, 1'b1, addr, be_n, wd, rd_n, wr_n);
    wait_acc(sel, stalls, acyc, ok);
    idle(sel);
    if (ok && !rd_n && wr_n) push(sel, exp, acyc);
  endtask

  task automatic drain(input bit sel);
    for (int n = 0; n < 40; n++) begin
      if ((sel ? qb_d.size() : qa_d.size()) == 0) break;
      @(negedge clk);
    end
    chk(sel ? "b_drain" : "a_drain", 32'(sel ? qb_d.size() : qa_d.size()), 32'd0);
  endtask

  initial begin
    int st;
    int acyc;
    int n_rv;
    bit ok;
    int b_acc[6];
    int b_st[6];

    rst_n = 1'b0;
    idle(1'b0);
    idle(1'b1);
    repeat (2) @(negedge clk);
    chk("rst_wait", 32'(a_wait), 32'd1);
    chk("rst_rvld", 32'(a_rvld), 32'd0);
    chk("rst_rdata", a_rdata, 32'd0);
    chk("rst_pend", 32'(a_pend), 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    rst_n = 1'b1;

    // Basic write then read with one wait state per command.
    cmd(1'b0, 23'h5, 4'h0, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, st);
    chk("t1_wr_stalls", 32'(st), 32'd1);
    cmd(1'b0, 23'h5, 4'hF, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, st);
    chk("t1_rd_stalls", 32'(st), 32'd1);
    drain(1'b0);

    // Byte enables merge into the existing word.
    cmd(1'b0, 23'h7, 4'h0, 32'h11223344, 1'b1, 1'b0, 32'h0, st);
    cmd(1'b0, 23'h7, 4'b1010, 32'hAABBCCDD, 1'b1, 1'b0, 32'h0, st);
    cmd(1'b0, 23'h7, 4'hF, 32'h0, 1'b0, 1'b1, 32'h11BB33DD, st);
    drain(1'b0);
    repeat (3) @(negedge clk);
    chk("t2_rdata_hold", a_rdata, 32'h11BB33DD);
    chk("t2_rvld_low", 32'(a_rvld), 32'd0);

    // Address aliasing beyond MEM_DEPTH.
    cmd(1'b0, 23'h400, 4'h0, 32'h5A5A5A5A, 1'b1, 1'b0, 32'h0, st);
    cmd(1'b0, 23'h000, 4'hF, 32'h0, 1'b0, 1'b1, 32'h5A5A5A5A, st);
    drain(1'b0);

    // Read and write together: executes as write, sticky error.
    chk("t5_err_before", 32'(a_err), 32'd0);
    cmd(1'b0, 23'h3, 4'h0, 32'h00000077, 1'b0, 1'b0, 32'h0, st);
    @(negedge clk);
    chk("t5_err_set", 32'(a_err), 32'd1);
    cmd(1'b0, 23'h3, 4'hF, 32'h0, 1'b0, 1'b1, 32'h00000077, st);
    drain(1'b0);
    chk("t5_err_sticky", 32'(a_err), 32'd1);

    // Zero-wait instance: preload, then six reads held continuously.
    for (int i = 0; i < 6; i++) begin
      cmd(1'b1, 23'(i), 4'h0, 32'hB0000000 + 32'(i), 1'b1, 1'b0, 32'h0, st);
      chk("b_wr_stalls", 32'(st), 32'd0);
    end
    @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 23'h0, 4'hF, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      wait_acc(1'b1, b_st[i], b_acc[i], ok);
      if (ok) push(1'b1, 32'hB0000000 + 32'(i), b_acc[i]);
      if (i < 5) drive(1'b1, 1'b1, 23'(i + 1), 4'hF, 32'h0, 1'b0, 1'b1);
      else idle(1'b1);
    end
    drain(1'b1);
    for (int i = 0; i < 4; i++) chk("b_early_stalls", 32'(b_st[i]), 32'd0);
    chk("b_5th_stalls", 32'(b_st[4]), 32'd1);
    chk("b_6th_stalls", 32'(b_st[5]), 32'd0);
    chk("b_5th_after_ret", 32'(b_acc[4] > b_first_ret), 32'd1);
    chk("b_5th_acc_cycle", 32'(b_acc[4] - b_acc[0]), 32'd5);
    chk("b_max_pend", 32'(b_max_pend), 32'd4);

    // Reset with two reads in flight.
    @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 23'h2, 4'hF, 32'h0, 1'b0, 1'b1);
    wait_acc(1'b1, st, acyc, ok);
    if (ok) push(1'b1, 32'hB0000002, acyc);
    drive(1'b1, 1'b1, 23'h3, 4'hF, 32'h0, 1'b0, 1'b1);
    wait_acc(1'b1, st, acyc, ok);
    if (ok) push(1'b1, 32'hB0000003, acyc);
    idle(1'b1);
    chk("b_pend_inflight", 32'(b_pend), 32'd2);
    rst_n = 1'b0;
    qa_d.delete(); qa_c.delete(); qb_d.delete(); qb_c.delete();
    @(negedge clk);
    chk("b_rst_wait", 32'(b_wait), 32'd1);
    chk("b_rst_pend", 32'(b_pend), 32'd0);
    chk("b_rst_rvld", 32'(b_rvld), 32'd0);
    chk("b_rst_rdata", b_rdata, 32'd0);
    chk("a_rst_wait", 32'(a_wait), 32'd1);
    chk("a_rst_err", 32'(a_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_rv = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (b_rvld === 1'b1) n_rv++;
    end
    chk("b_no_rvld_after_rst", 32'(n_rv), 32'd0);
    chk("b_pend_after_rst", 32'(b_pend), 32'd0);

    // RAM contents survive reset.
    cmd(1'b1, 23'h2, 4'hF, 32'h0, 1'b0, 1'b1, 32'hB0000002, st);
    drain(1'b1);
    cmd(1'b0, 23'h3, 4'hF, 32'h0, 1'b0, 1'b1, 32'h00000077, st);
    drain(1'b0);
    chk("a_err_cleared", 32'(a_err), 32'd0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
